sf_word_collector: RTL and testbench
====================================

Name: sf_word_collector

Overview:
- Receiving end of the byte-serial round datapath.
- Each cycle the F-function stage emits one Cn byte and one Dn byte, LSB byte first. This block reassembles each group of four byte pairs into a 32-bit Cn word and a 32-bit Dn word.
- Completed word pairs are buffered in a small FIFO and presented to the word-level round/output logic over a valid/ready handshake.
- Framing errors and buffer overflow are reported through sticky flags.

Parameters:
- WORD_BYTES, 4, bytes per word; the only supported value is 4.
- DEPTH, 2, number of word-pair entries in the output FIFO; legal values are 2 and 4.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  cn_byte/dn_byte carry a valid byte this cycle.
- in_first  input  1  marks byte 0 (the LSB) of a word; qualified by in_valid.
- cn_byte  input  8  Cn byte from the F stage.
- dn_byte  input  8  Dn byte from the F stage.
- out_valid  output  1  FIFO head holds a complete word pair.
- out_ready  input  1  downstream accepts the head this cycle.
- out_cn  output  32  assembled Cn word.
- out_dn  output  32  assembled Dn word.
- frame_err  output  1  sticky framing-error flag.
- overflow  output  1  sticky flag: a completed word was dropped.
- clear_err  input  1  clears frame_err and overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is reset_n, synchronous and active-low, sampled only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_cn=0, out_dn=0, frame_err=0, overflow=0.
  - Assembly returns to IDLE with byte_idx=0 and partial registers at 0.
  - FIFO emptied; read and write pointers at 0.
- Reset mid-word or mid-transfer discards all partial and buffered data.
- Assembly FSM states: IDLE and COLLECT.
  - byte_idx is a 2-bit counter.
  - Byte k is written to bits [8k+7:8k] of both partial words.
- IDLE:
  - in_valid & in_first: store byte 0, byte_idx=1, go to COLLECT.
  - in_valid & !in_first: byte discarded, frame_err set, stay in IDLE.
- COLLECT:
  - in_valid & !in_first: store byte at byte_idx, then increment byte_idx.
  - When byte 3 is stored: word complete, byte_idx wraps to 0, go to IDLE.
  - in_valid & in_first: the partial word is discarded and frame_err is set. The current byte restarts assembly as byte 0, byte_idx=1, and the FSM stays in COLLECT.
  - !in_valid: hold state; gaps of any length are allowed.
- Word completion and FIFO write:
  - The completed pair {byte3..byte0} is written to the FIFO on the same edge that stores byte 3.
  - The write succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle (simultaneous push/pop at full is legal).
  - Otherwise the word is dropped, overflow is set and FIFO contents are unchanged.
- Output:
  - The FIFO head is registered onto out_cn/out_dn, so out_valid rises 1 cycle after the edge that stored byte 3 (latency 1 when the FIFO was empty).
  - A pop occurs when out_valid & out_ready.
  - While out_valid & !out_ready, out_valid, out_cn and out_dn hold stable.
  - Order is strictly FIFO.
  - When the FIFO is empty, out_cn/out_dn keep their last value and out_valid=0.
- Simultaneous push and pop: at empty the pushed word becomes visible next cycle; at full the occupancy stays at DEPTH; otherwise the occupancy is unchanged.
- Sticky flags:
  - A flag is set by its event and cleared by clear_err.
  - If clear_err coincides with a set event, the set wins (flag=1 next cycle).
- Arithmetic: no arithmetic is performed on data; bytes are passed through bit-exact.

Test Plan:
- Basic assembly: after reset, send in_first on cn=0x11/dn=0xA1, then 0x22/0xA2, 0x33/0xA3, 0x44/0xA4 on consecutive cycles, with out_ready=1 -> out_valid=1 exactly one cycle after the 4th byte, out_cn=0x44332211, out_dn=0xA4A3A2A1; no flags set.
- Gapped input: insert 3 idle cycles between each byte of the same word -> the identical word is produced once and frame_err stays 0.
- Backpressure and overflow (DEPTH=2): hold out_ready=0 and send 3 words W0=0x00000001, W1=0x00000002, W2=0x00000003 -> W2 is dropped and overflow=1. Then raise out_ready -> W0 then W1 are delivered, with out_cn held stable while stalled.
- Push/pop at full: with the FIFO full and out_ready=1 on the cycle a 3rd word completes -> no overflow, and all three words are delivered in order.
- Framing: send 2 bytes, then in_first with 0x55 followed by 3 more bytes -> frame_err=1 and the output word has 0x55 in byte 0 (the partial word is discarded). Then send a non-first byte from IDLE -> the byte is discarded. Pulse clear_err -> frame_err=0.
- Reset mid-operation: assert reset_n=0 for 1 cycle after 2 bytes of a word with 1 word buffered -> on the next cycle out_valid=0, outputs=0, flags=0. A fresh 4-byte word then assembles correctly.

Source files
------------

// File: rtl/sf_word_collector.sv
// Reassembles byte-serial Cn/Dn pairs into 32-bit words and buffers completed
// word pairs in a small FIFO with a registered valid/ready output stage.
module sf_word_collector #(
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic [7:0]                cn_byte,
    input  logic [7:0]                dn_byte,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [8*WORD_BYTES-1:0]   out_cn,
    output logic [8*WORD_BYTES-1:0]   out_dn,
    output logic                      frame_err,
    output logic                      overflow,
    input  logic                      clear_err
);

    localparam int WB = 8 * WORD_BYTES;
    localparam int AW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t          state, state_n;
    logic [1:0]      byte_idx, byte_idx_n;
    logic [WB-1:0]   cn_part, dn_part, cn_part_n, dn_part_n;
    logic [WB-1:0]   word_cn, word_dn;
    logic            word_done, frame_evt;

    logic [2*WB-1:0] mem [DEPTH];
    logic [2*WB-1:0] head;
    logic [AW-1:0]   wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]   count, count_n, avail;
    logic            pop, full, push, drop, load;

    // Assembly FSM: next state, partial words and completion/framing events
    always_comb begin
        state_n    = state;
        byte_idx_n = byte_idx;
        cn_part_n  = cn_part;
        dn_part_n  = dn_part;
        word_cn    = cn_part;
        word_dn    = dn_part;
        word_done  = 1'b0;
        frame_evt  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_first) begin
                        cn_part_n[7:0] = cn_byte;
                        dn_part_n[7:0] = dn_byte;
                        byte_idx_n     = 2'd1;
                        state_n        = COLLECT;
                    end else begin
                        frame_evt = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (in_valid) begin
                    if (in_first) begin
                        frame_evt      = 1'b1;
                        cn_part_n[7:0] = cn_byte;
                        dn_part_n[7:0] = dn_byte;
                        byte_idx_n     = 2'd1;
                    end else begin
                        cn_part_n[{byte_idx, 3'b000} +: 8] = cn_byte;
                        dn_part_n[{byte_idx, 3'b000} +: 8] = dn_byte;
                        byte_idx_n = byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            word_done = 1'b1;
                            word_cn   = {cn_byte, cn_part[WB-9:0]};
                            word_dn   = {dn_byte, dn_part[WB-9:0]};
                            state_n   = IDLE;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            byte_idx <= '0;
            cn_part  <= '0;
            dn_part  <= '0;
        end else begin
            state    <= state_n;
            byte_idx <= byte_idx_n;
            cn_part  <= cn_part_n;
            dn_part  <= dn_part_n;
        end
    end

    // The output register mirrors the FIFO head; the entry stays counted in
    // occupancy until popped, so DEPTH includes the word being presented.
    always_comb begin
        pop      = out_valid & out_ready;
        full     = (count == CW'(DEPTH));
        push     = word_done & (~full | pop);
        drop     = word_done & full & ~pop;
        rd_ptr_n = rd_ptr + AW'(pop);
        avail    = count - CW'(pop);
        count_n  = count + CW'(push) - CW'(pop);
        load     = ~out_valid | pop;
        head     = mem[rd_ptr_n];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {word_cn, word_dn};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_cn    <= '0;
            out_dn    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            if (load) begin
                if (avail != '0) begin
                    out_valid <= 1'b1;
                    out_cn    <= head[2*WB-1:WB];
                    out_dn    <= head[WB-1:0];
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    // Sticky flags: a set event takes priority over clear_err
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            frame_err <= frame_evt | (frame_err & ~clear_err);
            overflow  <= drop | (overflow & ~clear_err);
        end
    end

endmodule

// File: tb/tb_sf_word_collector.sv
// Bench for sf_word_collector: fixed vector table, directed corner sequences
// and randomized traffic checked against a queue-based reference model.
module tb_sf_word_collector;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n, in_valid, in_first, out_ready, clear_err;
    logic [7:0]  cn_byte, dn_byte;
    logic        out_valid, frame_err, overflow;
    logic [31:0] out_cn, out_dn;

    always #5 clk = ~clk;

    sf_word_collector #(.WORD_BYTES(4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_first(in_first),
        .cn_byte(cn_byte), .dn_byte(dn_byte), .out_valid(out_valid),
        .out_ready(out_ready), .out_cn(out_cn), .out_dn(out_dn),
        .frame_err(frame_err), .overflow(overflow), .clear_err(clear_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: bytes of the word in progress, and the queue of
    // accepted word pairs (head is what the output presents).
    logic [15:0] acc [$];
    logic [63:0] mq  [$];
    logic        m_valid = 1'b0, m_frame = 1'b0, m_ovf = 1'b0;
    logic [31:0] m_cn = '0, m_dn = '0;
    logic [31:0] got [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic iv, input logic f,
                              input logic [7:0] cb, input logic [7:0] db,
                              input logic rdy, input logic clr);
        logic pop, fevt, oevt, done;
        logic [63:0] w;
        if (!rst) begin
            acc.delete(); mq.delete();
            m_valid = 1'b0; m_cn = '0; m_dn = '0; m_frame = 1'b0; m_ovf = 1'b0;
            return;
        end
        pop = m_valid && rdy;
        fevt = 1'b0; oevt = 1'b0; done = 1'b0; w = '0;
        if (iv) begin
            if (f) begin
                if (acc.size() != 0) fevt = 1'b1;
                acc.delete();
                acc.push_back({cb, db});
            end else if (acc.size() == 0) begin
                fevt = 1'b1;
            end else begin
                acc.push_back({cb, db});
                if (acc.size() == 4) begin
                    done = 1'b1;
                    w = {acc[3][15:8], acc[2][15:8], acc[1][15:8], acc[0][15:8],
                         acc[3][7:0],  acc[2][7:0],  acc[1][7:0],  acc[0][7:0]};
                    acc.delete();
                end
            end
        end
        if (pop) void'(mq.pop_front());
        if (!m_valid || pop) begin
            if (mq.size() > 0) begin
                m_valid = 1'b1;
                m_cn = mq[0][63:32];
                m_dn = mq[0][31:0];
            end else begin
                m_valid = 1'b0;
            end
        end
        if (done) begin
            if (mq.size() < DEPTH) mq.push_back(w);
            else oevt = 1'b1;
        end
        m_frame = fevt | (m_frame & ~clr);
        m_ovf   = oevt | (m_ovf & ~clr);
    endtask

    task automatic drive(input logic rst, input logic iv, input logic f, input logic [7:0] cb,
                         input logic [7:0] db, input logic rdy, input logic clr);
        reset_n = rst; in_valid = iv; in_first = f; cn_byte = cb; dn_byte = db;
        out_ready = rdy; clear_err = clr;
    endtask

    task automatic tick();
        if (reset_n && out_valid && out_ready) got.push_back(out_cn);
        @(posedge clk);
        model_step(reset_n, in_valid, in_first, cn_byte, dn_byte, out_ready, clear_err);
        #1;
    endtask

    task automatic cyc(input logic rst, input logic iv, input logic f, input logic [7:0] cb,
                       input logic [7:0] db, input logic rdy, input logic clr);
        drive(rst, iv, f, cb, db, rdy, clr);
        tick();
        check("model out_valid", out_valid, m_valid);
        check("model out_cn", out_cn, m_cn);
        check("model out_dn", out_dn, m_dn);
        check("model frame_err", frame_err, m_frame);
        check("model overflow", overflow, m_ovf);
    endtask

    task automatic send_word(input logic [31:0] cn, input logic [31:0] dn, input int gap, input logic rdy);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b1, k == 0, cn[8*k +: 8], dn[8*k +: 8], rdy, 1'b0);
            if (k < 3) repeat (gap) cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, rdy, 1'b0);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, rdy, 1'b0);
    endtask

    typedef struct {
        logic        iv, f;
        logic [7:0]  cb, db;
        logic        rdy, clr;
        logic        ev;
        logic [31:0] ecn, edn;
        logic        efr, eov;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1, 1, 8'h11, 8'hA1, 1, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[1] = '{1, 0, 8'h22, 8'hA2, 1, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[2] = '{1, 0, 8'h33, 8'hA3, 1, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[3] = '{1, 0, 8'h44, 8'hA4, 1, 0, 0, 32'h0, 32'h0, 0, 0};
        tbl[4] = '{0, 0, 8'h00, 8'h00, 1, 0, 1, 32'h44332211, 32'hA4A3A2A1, 0, 0};
        tbl[5] = '{0, 0, 8'h00, 8'h00, 1, 0, 0, 32'h44332211, 32'hA4A3A2A1, 0, 0};
        tbl[6] = '{1, 0, 8'h99, 8'h98, 1, 0, 0, 32'h44332211, 32'hA4A3A2A1, 1, 0};
        tbl[7] = '{0, 0, 8'h00, 8'h00, 1, 1, 0, 32'h44332211, 32'hA4A3A2A1, 0, 0};

        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_cn", out_cn, 32'h0);
        check("reset out_dn", out_dn, 32'h0);
        check("reset flags", {frame_err, overflow}, 2'b00);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].iv, tbl[i].f, tbl[i].cb, tbl[i].db, tbl[i].rdy, tbl[i].clr);
            tick();
            check($sformatf("tbl%0d out_valid", i), out_valid, tbl[i].ev);
            check($sformatf("tbl%0d out_cn", i), out_cn, tbl[i].ecn);
            check($sformatf("tbl%0d out_dn", i), out_dn, tbl[i].edn);
            check($sformatf("tbl%0d frame_err", i), frame_err, tbl[i].efr);
            check($sformatf("tbl%0d overflow", i), overflow, tbl[i].eov);
        end

        // Gapped bytes of one word
        got.delete();
        send_word(32'h44332211, 32'hA4A3A2A1, 3, 1'b1);
        idle(4, 1'b1);
        check("gap word count", got.size(), 1);
        if (got.size() > 0) check("gap word value", got[0], 32'h44332211);
        check("gap frame_err", frame_err, 1'b0);

        // Backpressure and overflow
        got.delete();
        send_word(32'h1, 32'h101, 0, 1'b0);
        send_word(32'h2, 32'h102, 0, 1'b0);
        send_word(32'h3, 32'h103, 0, 1'b0);
        idle(3, 1'b0);
        check("ovf flag", overflow, 1'b1);
        check("ovf stalled head", out_cn, 32'h1);
        idle(4, 1'b1);
        check("ovf delivered count", got.size(), 2);
        if (got.size() == 2) check("ovf order", {got[0], got[1]}, {32'h1, 32'h2});
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("ovf cleared", overflow, 1'b0);

        // Push and pop in the same cycle at full
        got.delete();
        send_word(32'h10, 32'h110, 0, 1'b0);
        send_word(32'h20, 32'h120, 0, 1'b0);
        idle(1, 1'b0);
        for (int k = 0; k < 4; k++)
            cyc(1'b1, 1'b1, k == 0, (k == 0) ? 8'h30 : 8'h00, (k == 0) ? 8'h30 : 8'h01, k == 3, 1'b0);
        idle(4, 1'b1);
        check("full push/pop overflow", overflow, 1'b0);
        check("full push/pop count", got.size(), 3);
        if (got.size() == 3) check("full push/pop order", {got[0], got[1], got[2]}, {32'h10, 32'h20, 32'h30});

        // Restart mid-word, then a stray byte from IDLE
        got.delete();
        cyc(1'b1, 1'b1, 1'b1, 8'h01, 8'h01, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h02, 8'h02, 1'b1, 1'b0);
        send_word(32'h88776655, 32'hC8C7C6C5, 0, 1'b1);
        idle(3, 1'b1);
        check("frame restart flag", frame_err, 1'b1);
        check("frame restart count", got.size(), 1);
        if (got.size() > 0) check("frame restart word", got[0], 32'h88776655);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("frame clear", frame_err, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'hEE, 8'hEE, 1'b1, 1'b0);
        idle(3, 1'b1);
        check("stray byte flag", frame_err, 1'b1);
        check("stray byte dropped", got.size(), 1);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check("stray clear", frame_err, 1'b0);

        // Reset with a buffered word, a partial word and a flag set
        send_word(32'hABABABAB, 32'hCDCDCDCD, 0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h77, 8'h77, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 8'h56, 8'h78, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset outs", {out_cn, out_dn}, 64'h0);
        check("midreset flags", {frame_err, overflow}, 2'b00);
        got.delete();
        send_word(32'hDEADBEEF, 32'h01234567, 0, 1'b1);
        idle(2, 1'b1);
        check("post-reset count", got.size(), 1);
        if (got.size() > 0) check("post-reset word", got[0], 32'hDEADBEEF);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic rst, iv, f, rdy, clr;
            rst = ($urandom_range(0, 399) != 0);
            iv  = ($urandom_range(0, 9) < 7);
            f   = (acc.size() == 0) ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 9) < 6);
            clr = ($urandom_range(0, 29) == 0);
            cyc(rst, iv, f, 8'($urandom), 8'($urandom), rdy, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
